// File: rtl/sdram_rd_pkg.sv
`default_nettype none
// sdram_rd_pkg: FSM states, default frame geometry and the FIFO credit check.
// Rev 1.0

package sdram_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  localparam logic [31:0] FRAME_WORDS_1080P = 32'hFD200;
  localparam logic [26:0] BUF0_BASE         = 27'h400_0000;
  localparam logic [26:0] BUF1_BASE         = 27'h40F_D200;

  // True when one more burst still fits below the FIFO high-water mark.
  function automatic logic credit_ok(input logic [31:0] used, input logic [31:0] outst,
                                     input logic [31:0] burst, input logic [31:0] limit);
    return (used + outst + burst) <= limit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_burst_reader_if.sv
`default_nettype none
// sdram_burst_reader_if: Avalon-MM read master bus plus pixel FIFO write port.
// Rev 1.0

interface sdram_burst_reader_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 27,
  parameter int CW         = 9
);
  logic [ADDR_WIDTH-1:0] avm_address_o;
  logic [7:0]            avm_burstcount_o;
  logic                  avm_read_o;
  logic                  avm_waitrequest_i;
  logic [DATA_WIDTH-1:0] avm_readdata_i;
  logic                  avm_readdatavalid_i;
  logic                  fifo_wrreq_o;
  logic [DATA_WIDTH:0]   fifo_data_o;
  logic [CW-1:0]         fifo_wrusedw_i;
  logic                  fifo_full_i;

  modport master (
    output avm_address_o, avm_burstcount_o, avm_read_o,
    input  avm_waitrequest_i, avm_readdata_i, avm_readdatavalid_i,
    output fifo_wrreq_o, fifo_data_o,
    input  fifo_wrusedw_i, fifo_full_i
  );

  modport slave (
    input  avm_address_o, avm_burstcount_o, avm_read_o,
    output avm_waitrequest_i, avm_readdata_i, avm_readdatavalid_i,
    input  fifo_wrreq_o, fifo_data_o,
    output fifo_wrusedw_i, fifo_full_i
  );
endinterface

`default_nettype wire

// File: rtl/frame_word_counter.sv
`default_nettype none
// frame_word_counter: counts 0..LIMIT-STEP in STEP increments and wraps; flags the last value.
// Rev 1.0

module frame_word_counter #(
  parameter int WIDTH = 20,
  parameter int LIMIT = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count,
  output logic             o_last
);
  localparam logic [WIDTH-1:0] C_LAST = WIDTH'(LIMIT - STEP);
  localparam logic [WIDTH-1:0] C_STEP = WIDTH'(STEP);

  logic [WIDTH-1:0] r_count;

  assign o_count = r_count;
  assign o_last  = (r_count == C_LAST);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= o_last ? '0 : r_count + C_STEP;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sdram_burst_reader.sv
`default_nettype none
// sdram_burst_reader: credit-flow Avalon-MM burst reader streaming double-buffered frames to a FIFO.
// Rev 1.0

module sdram_burst_reader #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 27,
  parameter int BURST_LEN   = 8,
  parameter int FIFO_DEPTH  = 256,
  parameter int HEADROOM    = 8,
  parameter int FRAME_WORDS = int'(sdram_rd_pkg::FRAME_WORDS_1080P),
  parameter logic [ADDR_WIDTH-1:0] BUF0_BASE = ADDR_WIDTH'(sdram_rd_pkg::BUF0_BASE),
  parameter logic [ADDR_WIDTH-1:0] BUF1_BASE = ADDR_WIDTH'(sdram_rd_pkg::BUF1_BASE)
) (
  input  logic                 sdram_clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic                 buf_sel_i,
  output logic                 active_buf_o,
  output logic                 primed_o,
  output logic                 frame_done_o,
  output logic                 overflow_err_o,
  sdram_burst_reader_if.master bus
);
  import sdram_rd_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = $clog2(FRAME_WORDS + 1);
  localparam logic [CW-1:0] C_BURST_CW = CW'(BURST_LEN);
  localparam logic [FW-1:0] C_BURST_FW = FW'(BURST_LEN);
  localparam logic [31:0]   C_LIMIT    = 32'(FIFO_DEPTH - HEADROOM);

  state_t                r_state, w_state_nxt;
  logic                  r_read, r_active_buf, r_primed, r_frame_done, r_overflow, r_wrreq;
  logic [ADDR_WIDTH-1:0] r_address;
  logic [CW-1:0]         r_outstanding;
  logic [DATA_WIDTH:0]   r_data;

  logic                  w_accept, w_credit, w_start, w_issue, w_buf_nxt, w_rdv;
  logic                  w_addr_last, w_rtn_last;
  logic [FW-1:0]         w_addr_cnt, w_addr_nxt, w_rtn_cnt;
  logic [CW-1:0]         w_out_committed;
  logic [ADDR_WIDTH-1:0] w_issue_addr;

  assign w_rdv    = bus.avm_readdatavalid_i;
  assign w_accept = r_read & ~bus.avm_waitrequest_i;

  // A burst accepted this cycle already consumes credit for a back-to-back issue.
  assign w_out_committed = r_outstanding + (w_accept ? C_BURST_CW : '0);
  assign w_credit = credit_ok(32'(bus.fifo_wrusedw_i), 32'(w_out_committed),
                              32'(BURST_LEN), C_LIMIT);

  // Buffer and word offset that the next issued burst will use.
  assign w_buf_nxt  = (w_start || (w_accept && w_addr_last)) ? buf_sel_i : r_active_buf;
  assign w_addr_nxt = w_start  ? '0 :
                      w_accept ? (w_addr_last ? '0 : w_addr_cnt + C_BURST_FW) : w_addr_cnt;
  assign w_issue_addr = (w_buf_nxt ? BUF1_BASE : BUF0_BASE) + ADDR_WIDTH'(w_addr_nxt);

  frame_word_counter #(.WIDTH(FW), .LIMIT(FRAME_WORDS), .STEP(BURST_LEN)) u_addr_cnt (
    .clk     (sdram_clk),
    .rst     (rst),
    .i_clr   (w_start),
    .i_inc   (w_accept),
    .o_count (w_addr_cnt),
    .o_last  (w_addr_last)
  );

  frame_word_counter #(.WIDTH(FW), .LIMIT(FRAME_WORDS), .STEP(1)) u_rtn_cnt (
    .clk     (sdram_clk),
    .rst     (rst),
    .i_clr   (w_start),
    .i_inc   (w_rdv),
    .o_count (w_rtn_cnt),
    .o_last  (w_rtn_last)
  );

  always_ff @(posedge sdram_clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable_i && (r_outstanding == '0)) w_state_nxt = ST_START;
      end
      ST_START: begin
        w_start     = 1'b1;
        w_issue     = enable_i && w_credit;
        w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_issue = enable_i && w_credit && (!r_read || w_accept);
        if (!enable_i && (!r_read || w_accept)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      r_read        <= 1'b0;
      r_address     <= BUF0_BASE;
      r_outstanding <= '0;
      r_active_buf  <= 1'b0;
      r_primed      <= 1'b0;
      r_frame_done  <= 1'b0;
      r_overflow    <= 1'b0;
      r_wrreq       <= 1'b0;
      r_data        <= '0;
    end else begin
      if (w_issue) begin
        r_read    <= 1'b1;
        r_address <= w_issue_addr;
      end else if (w_accept) begin
        r_read    <= 1'b0;
      end
      r_outstanding <= w_out_committed - CW'(w_rdv);
      r_active_buf  <= w_buf_nxt;
      if (w_start)                                        r_primed <= 1'b0;
      else if (32'(bus.fifo_wrusedw_i) >= C_LIMIT)        r_primed <= 1'b1;
      r_wrreq      <= w_rdv;
      r_frame_done <= w_rdv && w_rtn_last;
      if (w_rdv) r_data <= {(w_rtn_cnt == '0), bus.avm_readdata_i};
      if (w_rdv && bus.fifo_full_i) r_overflow <= 1'b1;
    end
  end

  assign bus.avm_address_o    = r_address;
  assign bus.avm_burstcount_o = 8'(BURST_LEN);
  assign bus.avm_read_o       = r_read;
  assign bus.fifo_wrreq_o     = r_wrreq;
  assign bus.fifo_data_o      = r_data;
  assign active_buf_o         = r_active_buf;
  assign primed_o             = r_primed;
  assign frame_done_o         = r_frame_done;
  assign overflow_err_o       = r_overflow;

endmodule

`default_nettype wire
